// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_stage_skid_pkg;

  // Stage occupancy: EMPTY = nothing held, ONE = main valid, FULL = main + skid valid
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_t;

  // True when the occupancy state presents a beat on the output
  function automatic logic ps_has_beat(input ps_state_t st);
    return st != PS_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, stall, flush, optional skid entry and bubble counter.
// Latency: 1 cycle from an accepted input beat to out_valid.
// Backpressure: SKID=1 gives a flop-driven in_ready (drops only when FULL); SKID=0 passes out_ready through combinationally.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int BUB_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [BUB_W-1:0]  bubble_cnt
);

  localparam logic [BUB_W-1:0] BUB_MAX = '1;

  ps_state_t         state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [BUB_W-1:0]  bub_q;
  logic              room;
  logic              in_xfer;
  logic              out_xfer;
  logic              skid_load;

  assign out_valid  = ps_has_beat(state);
  assign out_ctrl   = main_ctrl;
  assign out_data   = main_data;
  assign bubble_cnt = bub_q;

  // With a skid entry the room term is purely a decode of the state flop,
  // so the upstream ready path never sees downstream out_ready.
  generate
    if (SKID != 0) begin : g_room_reg
      assign room = (state != PS_FULL);
    end else begin : g_room_comb
      assign room = !out_valid || out_ready;
    end
  endgenerate

  assign in_ready  = ld && room;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = ld && out_valid && out_ready;
  // A beat arriving while the main register is held parks in the skid entry
  assign skid_load = (state == PS_ONE) && in_xfer && !out_xfer;

  // Occupancy state and the main (output) register; ctrl is zeroed whenever the stage empties
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state     <= PS_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
    end else if (ld) begin
      case (state)
        PS_EMPTY: begin
          if (in_xfer) begin
            state     <= PS_ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_xfer && (SKID != 0)) begin
            state <= PS_FULL;
          end else if (out_xfer) begin
            state     <= PS_EMPTY;
            main_ctrl <= '0;
          end
        end
        PS_FULL: begin
          if (out_xfer) begin
            state     <= PS_ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end
        default: begin
          state     <= PS_EMPTY;
          main_ctrl <= '0;
        end
      endcase
    end
  end

  // Skid entry exists only when SKID is set; otherwise it reads as constant zero
  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk) begin
        if (!reset || flush) begin
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (ld && skid_load) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
    end else begin : g_no_skid
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

  // Saturating count of enabled cycles with no beat on the output; survives flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      bub_q <= '0;
    end else if (ld && !flush && !out_valid && (bub_q != BUB_MAX)) begin
      bub_q <= bub_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset, ld, flush, in_valid, out_ready;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [15:0] oc0, oc1, oc2;
  logic [31:0] od0, od1, od2;
  logic [7:0]  bc0, bc1;
  logic [1:0]  bc2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: a FIFO of held beats per instance (k=0 no skid, k=1 skid)
  logic [47:0] q0[$];
  logic [47:0] q1[$];
  logic [31:0] mlast[2];
  int          mbub[2];

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(32), .SKID(0), .BUB_W(8)) dut0 (
    .clk(clk), .reset(reset), .ld(ld), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .bubble_cnt(bc0));

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(32), .SKID(1), .BUB_W(8)) dut1 (
    .clk(clk), .reset(reset), .ld(ld), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .bubble_cnt(bc1));

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(32), .SKID(1), .BUB_W(2)) dut2 (
    .clk(clk), .reset(reset), .ld(ld), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_ctrl(oc2), .out_data(od2),
    .bubble_cnt(bc2));

  typedef struct {
    logic        ld;
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
  } vec_t;

  vec_t tbl[24];

  function automatic logic [15:0] mk_ctrl(input logic [31:0] d);
    return {d[7:0] ^ 8'h3C, d[15:8] ^ 8'hC3};
  endfunction

  function automatic vec_t v(input logic l, input logic f, input logic i, input logic [31:0] d,
                             input logic o, input logic eir, input logic eov, input logic [31:0] eod);
    vec_t r;
    r.ld = l; r.fl = f; r.iv = i; r.d = d; r.ordy = o;
    r.e_ir = eir; r.e_ov = eov; r.e_od = eod;
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic f, input logic i, input logic [31:0] d, input logic o);
    ld = l; flush = f; in_valid = i; in_data = d; in_ctrl = mk_ctrl(d); out_ready = o;
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      int          sz;
      logic [47:0] hd;
      logic        e_ov, e_ir, a_ov, a_ir;
      logic [15:0] e_oc, a_oc;
      logic [31:0] e_od, a_od;
      logic [7:0]  a_bc;
      if (k == 0) begin sz = q0.size(); hd = (sz > 0) ? q0[0] : 48'h0; end
      else        begin sz = q1.size(); hd = (sz > 0) ? q1[0] : 48'h0; end
      e_ov = (sz > 0);
      e_oc = e_ov ? hd[47:32] : 16'h0;
      e_od = e_ov ? hd[31:0] : mlast[k];
      e_ir = ld && ((k == 1) ? (sz < 2) : (sz == 0 || out_ready));
      a_ov = (k == 0) ? ov0 : ov1;
      a_ir = (k == 0) ? ir0 : ir1;
      a_oc = (k == 0) ? oc0 : oc1;
      a_od = (k == 0) ? od0 : od1;
      a_bc = (k == 0) ? bc0 : bc1;
      check($sformatf("model%0d_out_valid", k), 64'(a_ov), 64'(e_ov));
      check($sformatf("model%0d_in_ready", k), 64'(a_ir), 64'(e_ir));
      check($sformatf("model%0d_out_ctrl", k), 64'(a_oc), 64'(e_oc));
      check($sformatf("model%0d_out_data", k), 64'(a_od), 64'(e_od));
      check($sformatf("model%0d_bubble_cnt", k), 64'(a_bc), 64'(mbub[k]));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic [47:0] tq[$];
      logic        rdy, ox, ix;
      if (k == 0) tq = q0; else tq = q1;
      if (!reset) begin
        tq.delete(); mlast[k] = 32'h0; mbub[k] = 0;
      end else if (flush) begin
        tq.delete(); mlast[k] = 32'h0;
      end else if (ld) begin
        if (tq.size() == 0 && mbub[k] < 255) mbub[k]++;
        rdy = (k == 1) ? (tq.size() < 2) : (tq.size() == 0 || out_ready);
        ox  = (tq.size() > 0) && out_ready;
        ix  = in_valid && rdy;
        if (ox) begin
          mlast[k] = tq[0][31:0];
          void'(tq.pop_front());
        end
        if (ix) tq.push_back({in_ctrl, in_data});
      end
      if (k == 0) q0 = tq; else q1 = tq;
    end
  endtask

  // One clock: compare against the model away from the edge, then advance the model with the edge
  task automatic step();
    #1;
    if (chk_en) model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] sat_exp[6];
    mlast[0] = 0; mlast[1] = 0; mbub[0] = 0; mbub[1] = 0;

    // Reset held for two cycles with a valid beat offered
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h99, 1'b1);
    @(negedge clk);
    step();
    step();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_en = 1'b1;
    #1;
    check("reset_out_valid", 64'(ov1), 64'(0));
    check("reset_out_ctrl", 64'(oc1), 64'(0));
    check("reset_out_data", 64'(od1), 64'(0));
    check("reset_bubble_cnt", 64'(bc1), 64'(0));
    check("reset_in_ready", 64'(ir1), 64'(1));

    // Bubble counter saturation on the 2-bit instance
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("sat_bubble_cnt_%0d", i), 64'(bc2), 64'(sat_exp[i]));
    end

    // Streaming, back-pressure and stall vectors for the skid instance
    for (int i = 0; i < 8; i++)
      tbl[i] = v(1, 0, 1, 32'(i + 1), 1, 1, (i != 0), 32'(i));
    tbl[8]  = v(1, 0, 0, 32'h0, 1, 1, 1, 32'd8);
    tbl[9]  = v(1, 0, 0, 32'h0, 1, 1, 0, 32'd8);
    tbl[10] = v(1, 0, 1, 32'hA, 0, 1, 0, 32'd8);
    tbl[11] = v(1, 0, 1, 32'hB, 0, 1, 1, 32'hA);
    tbl[12] = v(1, 0, 1, 32'hC, 0, 0, 1, 32'hA);
    tbl[13] = v(1, 0, 1, 32'hC, 0, 0, 1, 32'hA);
    tbl[14] = v(1, 0, 1, 32'hC, 1, 0, 1, 32'hA);
    tbl[15] = v(1, 0, 1, 32'hC, 1, 1, 1, 32'hB);
    tbl[16] = v(1, 0, 0, 32'h0, 1, 1, 1, 32'hC);
    tbl[17] = v(1, 0, 0, 32'h0, 1, 1, 0, 32'hC);
    tbl[18] = v(1, 0, 1, 32'hE, 0, 1, 0, 32'hC);
    tbl[19] = v(0, 0, 0, 32'h0, 1, 0, 1, 32'hE);
    tbl[20] = v(0, 0, 0, 32'h0, 1, 0, 1, 32'hE);
    tbl[21] = v(0, 0, 0, 32'h0, 1, 0, 1, 32'hE);
    tbl[22] = v(1, 0, 0, 32'h0, 1, 1, 1, 32'hE);
    tbl[23] = v(1, 0, 0, 32'h0, 1, 1, 0, 32'hE);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].ld, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(ir1), 64'(tbl[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), 64'(ov1), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d_out_data", i), 64'(od1), 64'(tbl[i].e_od));
      check($sformatf("vec%0d_out_ctrl", i), 64'(oc1),
            64'(tbl[i].e_ov ? mk_ctrl(tbl[i].e_od) : 16'h0));
      step();
    end

    // Flush from FULL with a beat offered in the same cycle
    drive(1, 0, 1, 32'h50, 0); step();
    drive(1, 0, 1, 32'h51, 0); step();
    drive(1, 1, 1, 32'hD, 0);
    #1;
    check("flush_full_in_ready", 64'(ir1), 64'(0));
    step();
    drive(1, 0, 0, 32'h0, 1);
    #1;
    check("flush_out_valid", 64'(ov1), 64'(0));
    check("flush_out_ctrl", 64'(oc1), 64'(0));
    check("flush_out_data", 64'(od1), 64'(0));
    check("flush_in_ready", 64'(ir1), 64'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("flush_no_d_%0d", i), 64'(ov1), 64'(0));
    end

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
            1'($urandom), $urandom, 1'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
